// File: rtl/rs_issue_select.sv
// Issue-select stage: round-robin scan of ready RS entries, up to ISSUE_WIDTH grants
// per cycle (one per free FU), with granted packets registered into the issue pipeline.

package rs_issue_pkg;
  typedef struct packed {
    logic [5:0]  rob_tag;
    logic [2:0]  fu_type;
    logic [4:0]  dst;
    logic [15:0] imm;
  } rs_entry_t;
endpackage

module rs_issue_select
  import rs_issue_pkg::*;
#(
  parameter  int RS_DEPTH    = 16,
  parameter  int ISSUE_WIDTH = 2,
  parameter  int FU_NUM      = 8,
  localparam int PTR_W       = $clog2(RS_DEPTH),
  localparam int FU_W        = $clog2(FU_NUM)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  stall_i,
  input  logic [RS_DEPTH-1:0]                   entry_ready_i,
  input  logic [RS_DEPTH-1:0][FU_W-1:0]         entry_fu_type_i,
  input  rs_entry_t [RS_DEPTH-1:0]              entry_pkt_i,
  input  logic [FU_NUM-1:0]                     fu_free_i,
  output logic [RS_DEPTH-1:0]                   issue_grant_o,
  output logic [ISSUE_WIDTH-1:0]                issue_valid_o,
  output rs_entry_t [ISSUE_WIDTH-1:0]           issue_pkt_o,
  output logic [ISSUE_WIDTH-1:0][FU_W-1:0]      issue_fu_o,
  output logic [PTR_W-1:0]                      rr_ptr_o
);

  logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [ISSUE_WIDTH-1:0]            issue_valid_q, issue_valid_d;
  rs_entry_t [ISSUE_WIDTH-1:0]       issue_pkt_q, issue_pkt_d;
  logic [ISSUE_WIDTH-1:0][FU_W-1:0]  issue_fu_q, issue_fu_d;

  logic [RS_DEPTH-1:0]               grant;
  logic [FU_NUM-1:0]                 fu_claimed;
  logic [PTR_W:0]                    scan_sum;
  logic [PTR_W-1:0]                  scan_idx;
  logic [PTR_W-1:0]                  last_idx;
  logic [FU_W-1:0]                   scan_fu;
  logic                              any_grant;
  int                                n_grant;
  logic [ISSUE_WIDTH-1:0]            slot_valid;
  rs_entry_t [ISSUE_WIDTH-1:0]       slot_pkt;
  logic [ISSUE_WIDTH-1:0][FU_W-1:0]  slot_fu;

  // Sequential scan from the priority pointer; the k-th grant lands in slot k,
  // so valid slots are always packed from slot 0.
  always_comb begin
    // NOTE: blocking assignments are intended here -- fu_claimed and n_grant must
    // reflect earlier iterations of the same scan within this evaluation.
    grant      = '0;
    fu_claimed = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    scan_fu    = '0;
    last_idx   = rr_ptr_q;
    any_grant  = 1'b0;
    n_grant    = 0;
    slot_valid = '0;
    slot_pkt   = '0;
    slot_fu    = '0;
    if (!reset && !stall_i && !flush) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(j);
        if (scan_sum >= (PTR_W+1)'(RS_DEPTH)) begin
          scan_sum = scan_sum - (PTR_W+1)'(RS_DEPTH);
        end
        scan_idx = scan_sum[PTR_W-1:0];
        scan_fu  = entry_fu_type_i[scan_idx];
        if (entry_ready_i[scan_idx] && fu_free_i[scan_fu] && !fu_claimed[scan_fu]
            && (n_grant < ISSUE_WIDTH)) begin
          grant[scan_idx]     = 1'b1;
          fu_claimed[scan_fu] = 1'b1;
          for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (n_grant == k) begin
              slot_valid[k] = 1'b1;
              slot_pkt[k]   = entry_pkt_i[scan_idx];
              slot_fu[k]    = scan_fu;
            end
          end
          n_grant   = n_grant + 1;
          last_idx  = scan_idx;
          any_grant = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_idx == PTR_W'(RS_DEPTH - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  // Flush beats stall; a stall freezes the bundle already presented downstream.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_pkt_d   = issue_pkt_q;
    issue_fu_d    = issue_fu_q;
    if (flush) begin
      issue_valid_d = '0;
      issue_pkt_d   = '0;
      issue_fu_d    = '0;
    end else if (!stall_i) begin
      issue_valid_d = slot_valid;
      issue_pkt_d   = slot_pkt;
      issue_fu_d    = slot_fu;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      issue_valid_q <= '0;
      issue_pkt_q   <= '0;
      issue_fu_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_pkt_q   <= issue_pkt_d;
      issue_fu_q    <= issue_fu_d;
    end
  end

  assign issue_grant_o = grant;
  assign issue_valid_o = issue_valid_q;
  assign issue_pkt_o   = issue_pkt_q;
  assign issue_fu_o    = issue_fu_q;
  assign rr_ptr_o      = rr_ptr_q;

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: stimulus pushes expected register state into a
// scoreboard queue; a monitor pops and compares after each rising edge.

module tb_rs_issue_select;
  import rs_issue_pkg::*;

  logic                        clock;
  logic                        reset;
  logic                        flush;
  logic                        stall_i;
  logic [15:0]                 entry_ready_i;
  logic [15:0][2:0]            entry_fu_type_i;
  rs_entry_t [15:0]            entry_pkt_i;
  logic [7:0]                  fu_free_i;
  logic [15:0]                 issue_grant_o;
  logic [1:0]                  issue_valid_o;
  rs_entry_t [1:0]             issue_pkt_o;
  logic [1:0][2:0]             issue_fu_o;
  logic [3:0]                  rr_ptr_o;

  rs_issue_select #(.RS_DEPTH(16), .ISSUE_WIDTH(2), .FU_NUM(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .stall_i         (stall_i),
    .entry_ready_i   (entry_ready_i),
    .entry_fu_type_i (entry_fu_type_i),
    .entry_pkt_i     (entry_pkt_i),
    .fu_free_i       (fu_free_i),
    .issue_grant_o   (issue_grant_o),
    .issue_valid_o   (issue_valid_o),
    .issue_pkt_o     (issue_pkt_o),
    .issue_fu_o      (issue_fu_o),
    .rr_ptr_o        (rr_ptr_o)
  );

  typedef struct {
    int              id;
    logic [1:0]      valid;
    rs_entry_t [1:0] pkt;
    logic [1:0][2:0] fu;
    logic [3:0]      ptr;
    bit              chk_pkt;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic rs_entry_t mk_pkt(input int i);
    rs_entry_t p;
    p.rob_tag = 6'(i) ^ 6'h2A;
    p.fu_type = 3'(i);
    p.dst     = 5'(31 - i);
    p.imm     = 16'hC000 | 16'(i * 3);
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, check the combinational grant,
  // and queue the register state expected after the next rising edge.
  task automatic step(input logic rst, input logic stl, input logic fl,
                      input logic [15:0] rdy, input logic [7:0] free,
                      input logic [15:0] exp_grant, input logic [1:0] exp_valid,
                      input int s0, input int s1, input logic [3:0] exp_ptr);
    exp_t e;
    int   s[2];
    @(negedge clock);
    reset         = rst;
    stall_i       = stl;
    flush         = fl;
    entry_ready_i = rdy;
    fu_free_i     = free;
    #1;
    vec_id++;
    check($sformatf("v%0d grant", vec_id), 64'(issue_grant_o), 64'(exp_grant));
    s[0] = s0;
    s[1] = s1;
    e.id      = vec_id;
    e.valid   = '0;
    e.pkt     = '0;
    e.fu      = '0;
    e.ptr     = '0;
    e.chk_pkt = 1'b1;
    if (rst) begin
      e.ptr = '0;
    end else if (fl) begin
      e.ptr     = exp_ptr;
      e.chk_pkt = 1'b0;
    end else if (stl) begin
      e    = last_exp;
      e.id = vec_id;
    end else begin
      e.valid = exp_valid;
      e.ptr   = exp_ptr;
      for (int k = 0; k < 2; k++) begin
        if (exp_valid[k]) begin
          e.pkt[k] = mk_pkt(s[k]);
          e.fu[k]  = entry_fu_type_i[s[k]];
        end
      end
    end
    last_exp = e;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("v%0d valid", e.id), 64'(issue_valid_o), 64'(e.valid));
        check($sformatf("v%0d rr_ptr", e.id), 64'(rr_ptr_o), 64'(e.ptr));
        if (e.chk_pkt) begin
          for (int k = 0; k < 2; k++) begin
            check($sformatf("v%0d pkt%0d", e.id, k), 64'(issue_pkt_o[k]), 64'(e.pkt[k]));
            check($sformatf("v%0d fu%0d", e.id, k), 64'(issue_fu_o[k]), 64'(e.fu[k]));
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset           = 1'b1;
    stall_i         = 1'b0;
    flush           = 1'b0;
    entry_ready_i   = '0;
    fu_free_i       = '0;
    entry_fu_type_i = '0;
    for (int i = 0; i < 16; i++) entry_pkt_i[i] = mk_pkt(i);

    step(1, 0, 0, 16'h0000, 8'hFF, 16'h0000, 2'b00, 0, 0, 4'd0);
    step(1, 0, 0, 16'h00FF, 8'hFF, 16'h0000, 2'b00, 0, 0, 4'd0);

    // Entries 3 and 7, distinct FUs, scan from 0.
    entry_fu_type_i[3] = 3'd1;
    entry_fu_type_i[7] = 3'd2;
    step(0, 0, 0, 16'h0088, 8'hFF, 16'h0088, 2'b11, 3, 7, 4'd8);

    // From 8: 9 and 12 win, 2 waits for the next cycle.
    entry_fu_type_i[2]  = 3'd3;
    entry_fu_type_i[9]  = 3'd4;
    entry_fu_type_i[12] = 3'd5;
    step(0, 0, 0, 16'h1204, 8'hFF, 16'h1200, 2'b11, 9, 12, 4'd13);
    step(0, 0, 0, 16'h0004, 8'hFF, 16'h0004, 2'b01, 2, 0, 4'd3);

    // Fresh reset, then three entries all on FU 4: only one grant.
    step(1, 0, 0, 16'h0000, 8'hFF, 16'h0000, 2'b00, 0, 0, 4'd0);
    entry_fu_type_i[0] = 3'd4;
    entry_fu_type_i[1] = 3'd4;
    entry_fu_type_i[2] = 3'd4;
    step(0, 0, 0, 16'h0007, 8'h10, 16'h0001, 2'b01, 0, 0, 4'd1);

    // All FUs busy, then freed.
    entry_fu_type_i[5] = 3'd0;
    entry_fu_type_i[6] = 3'd1;
    step(0, 0, 0, 16'h0060, 8'h00, 16'h0000, 2'b00, 0, 0, 4'd1);
    step(0, 0, 0, 16'h0060, 8'hFF, 16'h0060, 2'b11, 5, 6, 4'd7);

    // Empty ready vector leaves the pointer alone.
    step(0, 0, 0, 16'h0000, 8'hFF, 16'h0000, 2'b00, 0, 0, 4'd7);

    // Bundle, then three stall cycles with new work pending, then release.
    entry_fu_type_i[8]  = 3'd6;
    entry_fu_type_i[10] = 3'd7;
    step(0, 0, 0, 16'h0500, 8'hFF, 16'h0500, 2'b11, 8, 10, 4'd11);
    entry_fu_type_i[11] = 3'd0;
    entry_fu_type_i[12] = 3'd1;
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 0, 16'h1800, 8'hFF, 16'h0000, 2'b00, 0, 0, 4'd0);
    end
    step(0, 0, 0, 16'h1800, 8'hFF, 16'h1800, 2'b11, 11, 12, 4'd13);

    // Width limit with pointer wrap: 14 and 15 win, entry 0 deferred.
    entry_fu_type_i[14] = 3'd0;
    entry_fu_type_i[15] = 3'd1;
    entry_fu_type_i[0]  = 3'd2;
    step(0, 0, 0, 16'hC001, 8'hFF, 16'hC000, 2'b11, 14, 15, 4'd0);
    step(0, 0, 0, 16'h0001, 8'hFF, 16'h0001, 2'b01, 0, 0, 4'd1);

    // Flush together with stall and ready work.
    entry_fu_type_i[3] = 3'd0;
    step(0, 1, 1, 16'h0008, 8'hFF, 16'h0000, 2'b00, 0, 0, 4'd1);
    step(0, 0, 0, 16'h0008, 8'hFF, 16'h0008, 2'b01, 3, 0, 4'd4);

    // Reset while stalled clears everything; stall then holds the cleared state.
    step(1, 1, 0, 16'h0020, 8'hFF, 16'h0000, 2'b00, 0, 0, 4'd0);
    step(0, 1, 0, 16'h0020, 8'hFF, 16'h0000, 2'b00, 0, 0, 4'd0);
    step(0, 0, 0, 16'h0020, 8'hFF, 16'h0020, 2'b01, 5, 0, 4'd6);

    @(negedge clock);
    entry_ready_i = '0;
    repeat (3) @(posedge clock);
    #2;
    check("scoreboard_drain", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
